// File: rtl/fifo_tx_pkg.sv
// Shared types and sizing helpers for the tx/rx byte FIFOs.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_tx_pkg;

  // Defaults shared with the rx FIFO so both sides size identically.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 256;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } tx_state_e;

  // Pointer/level width: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_tx_drain_if.sv
// Write-side and UART-side signals of the draining tx FIFO.
// Latency: n/a (wiring only).
// Backpressure: full/overflow toward the writer, tx_busy from the UART.
interface fifo_tx_drain_if
  import fifo_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);
  localparam int LW = ptr_width(DEPTH);

  logic                  we;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  clr_err;
  logic                  tx_busy;
  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;

  // Environment side: result writer plus UART serialiser.
  modport master (
    output we, w_data, clr_err, tx_busy,
    input  full, almost_full, empty, level, overflow, start, tx_data
  );

  // FIFO side.
  modport slave (
    input  we, w_data, clr_err, tx_busy,
    output full, almost_full, empty, level, overflow, start, tx_data
  );

endinterface

// File: rtl/fifo_mem_core.sv
// Storage array, wrap-bit pointers, level, status flags and sticky overflow.
// Latency: a write is visible to rd_data and the flags one edge later.
// Backpressure: writes while full are dropped and latch overflow.
module fifo_mem_core
  import fifo_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic                         pop,
  input  logic                         clr_err,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         full,
  output logic                         almost_full,
  output logic                         empty,
  output logic [ptr_width(DEPTH)-1:0]  level,
  output logic                         overflow
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic                  wr_en;

  // Full is judged before any same-cycle pop; flush beats a write.
  assign wr_en = we && !full && !flush;

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_ptr[AW-1:0]] <= w_data;
  end

  // Pointer advance; the extra MSB lets full and empty be told apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else if (flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_en) w_ptr <= w_ptr + 1'b1;
      if (pop)   r_ptr <= r_ptr + 1'b1;
    end
  end

  // Sticky overflow; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             overflow <= 1'b0;
    else if (we && full)    overflow <= 1'b1;
    else if (clr_err)       overflow <= 1'b0;
  end

  // Level is the pointer distance, so a write and pop together cancel.
  assign level       = w_ptr - r_ptr;
  assign full        = (level == PW'(DEPTH));
  assign almost_full = (level >= PW'(AFULL_THRESH));
  assign empty       = (level == '0);
  assign rd_data     = mem[r_ptr[AW-1:0]];

endmodule

// File: rtl/fifo_tx_drain.sv
// Tx FIFO that drains itself into a UART via start/busy, with ack-timeout retry (optional flush: FIFO_TX_DRAIN_FLUSH_EN).
// Latency: start pulses one edge after a word lands in an empty FIFO with the UART idle.
// Backpressure: writes while full are dropped and flagged; draining stalls while tx_busy is high.
module fifo_tx_drain
  import fifo_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 4,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef FIFO_TX_DRAIN_FLUSH_EN
  input  logic            flush,
`endif
  fifo_tx_drain_if.slave  bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic                  pop;
  logic                  empty;
  logic                  flush_i;
  logic [DATA_WIDTH-1:0] rd_data;
  tx_state_e             state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  start_q, start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

`ifdef FIFO_TX_DRAIN_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  fifo_mem_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .AFULL_THRESH(AFULL_THRESH)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (bus.we),
    .w_data     (bus.w_data),
    .pop        (pop),
    .clr_err    (bus.clr_err),
    .flush      (flush_i),
    .rd_data    (rd_data),
    .full       (bus.full),
    .almost_full(bus.almost_full),
    .empty      (empty),
    .level      (bus.level),
    .overflow   (bus.overflow)
  );

  assign bus.empty   = empty;
  assign bus.start   = start_q;
  assign bus.tx_data = tx_data_q;

  // Drain sequencing: pop when the UART is free, retry start until busy is seen.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    start_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !bus.tx_busy) begin
          pop       = 1'b1;
          tx_data_d = rd_data;
          start_d   = 1'b1;
          timer_d   = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // UART missed the pulse: offer the same byte again.
          start_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush abandons the hand-off; a byte already on the line finishes on its own.
    if (flush_i) begin
      pop     = 1'b0;
      start_d = 1'b0;
      timer_d = '0;
      state_d = IDLE;
    end
  end

  // Drain state, retry timer and the registered UART-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      start_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Self-checking bench: queue-based reference of the draining tx FIFO plus directed and random traffic.
// Latency: n/a.
// Backpressure: a small UART emulator answers start with a 10-cycle busy window.
module tb_fifo_tx_drain;
  import fifo_tx_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AFULL = DEPTH - 4;
  localparam int ACK   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
`ifdef FIFO_TX_DRAIN_FLUSH_EN
  logic flush = 1'b0;
`endif

  fifo_tx_drain_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fifo_tx_drain #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .AFULL_THRESH(AFULL),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef FIFO_TX_DRAIN_FLUSH_EN
    .flush(flush),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Contents as a plain queue; a hand-off is "active" from the pop until the
  // UART has raised and dropped busy; without busy the same byte is offered
  // again after every ACK elapsed cycles.
  logic [7:0] q[$];
  logic [7:0] m_tx     = 8'h00;
  bit         m_ovf    = 1'b0;
  bit         m_start  = 1'b0;
  bit         m_active = 1'b0;
  bit         m_acked  = 1'b0;
  int         m_age    = 0;

  task automatic model_step();
    bit flushing;
    bit was_full;
    bit accept;
    if (!rst_n) begin
      q.delete();
      m_tx = 8'h00; m_ovf = 1'b0; m_start = 1'b0;
      m_active = 1'b0; m_acked = 1'b0; m_age = 0;
      return;
    end
    flushing = 1'b0;
`ifdef FIFO_TX_DRAIN_FLUSH_EN
    flushing = flush;
`endif
    was_full = (q.size() == DEPTH);
    accept   = bus.we && !was_full && !flushing;
    if (bus.we && was_full) m_ovf = 1'b1;
    else if (bus.clr_err)   m_ovf = 1'b0;
    if (flushing) begin
      q.delete();
      m_start = 1'b0; m_active = 1'b0; m_acked = 1'b0; m_age = 0;
      return;
    end
    m_start = 1'b0;
    if (!m_active) begin
      if (q.size() > 0 && !bus.tx_busy) begin
        m_tx = q.pop_front();
        m_start = 1'b1; m_active = 1'b1; m_acked = 1'b0; m_age = 0;
      end
    end else if (!m_acked) begin
      if (bus.tx_busy) m_acked = 1'b1;
      else begin
        m_age++;
        if (m_age == ACK) begin
          m_start = 1'b1;
          m_age = 0;
        end
      end
    end else if (!bus.tx_busy) begin
      m_active = 1'b0;
    end
    if (accept) q.push_back(bus.w_data);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("level",       32'(bus.level),     32'(q.size()));
      chk("empty",       32'(bus.empty),     32'(q.size() == 0));
      chk("full",        32'(bus.full),      32'(q.size() == DEPTH));
      chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= AFULL));
      chk("overflow",    32'(bus.overflow),  32'(m_ovf));
      chk("start",       32'(bus.start),     32'(m_start));
      chk("tx_data",     32'(bus.tx_data),   32'(m_tx));
    end
  end

  // ---------------- UART emulator ----------------
  bit         uart_mode  = 1'b0;
  bit         busy_force = 1'b0;
  int         ucnt       = 0;
  logic [7:0] rxq[$];

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (uart_mode) begin
        if (ucnt > 0) ucnt--;
        else if (bus.start) begin
          ucnt = 10;
          rxq.push_back(bus.tx_data);
        end
        bus.tx_busy = (ucnt > 0);
      end else begin
        ucnt = 0;
        bus.tx_busy = busy_force;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drained(input string name);
    int waited;
    waited = 0;
    while (waited < 6000 && !(bus.empty && !bus.tx_busy && ucnt == 0 && !bus.start)) begin
      cyc(1);
      waited++;
    end
    chk(name, 32'(waited < 6000), 32'd1);
    cyc(3);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  logic [7:0] expq[$];
  int n, mism, total, burst;
  logic [7:0] d;

  initial begin
    bus.we = 1'b0; bus.w_data = '0; bus.clr_err = 1'b0;
    cyc(3);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_afull", 32'(bus.almost_full), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Single byte: start one edge after empty falls.
    bus.we = 1'b1; bus.w_data = 8'hA5;
    cyc(1);
    bus.we = 1'b0;
    chk("a5_empty_fell", 32'(bus.empty), 32'd0);
    chk("a5_start_not_yet", 32'(bus.start), 32'd0);
    cyc(1);
    chk("a5_start", 32'(bus.start), 32'd1);
    chk("a5_tx_data", 32'(bus.tx_data), 32'hA5);
    chk("a5_level", 32'(bus.level), 32'd0);

    // No ack: same byte offered again ACK cycles later.
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!bus.start && n < 40);
    chk("retry_spacing", 32'(n), 32'd16);
    chk("retry_same_byte", 32'(bus.tx_data), 32'hA5);
    busy_force = 1'b1;
    cyc(3);
    chk("ack_no_extra_start", 32'(bus.start), 32'd0);
    busy_force = 1'b0;
    cyc(3);

    // Fill to full with the UART busy.
    busy_force = 1'b1;
    cyc(1);
    for (int i = 0; i < 256; i++) begin
      bus.we = 1'b1; bus.w_data = i[7:0];
      cyc(1);
      if (i == 250) chk("afull_below_252", 32'(bus.almost_full), 32'd0);
      if (i == 251) chk("afull_at_252", 32'(bus.almost_full), 32'd1);
    end
    bus.w_data = 8'hEE;
    cyc(1);
    bus.we = 1'b0;
    chk("full_flag", 32'(bus.full), 32'd1);
    chk("full_level", 32'(bus.level), 32'd256);
    chk("overflow_set", 32'(bus.overflow), 32'd1);
    bus.clr_err = 1'b1;
    cyc(1);
    bus.clr_err = 1'b0;
    chk("overflow_cleared", 32'(bus.overflow), 32'd0);

    // Write while full coincident with the first pop.
    rxq.delete();
    busy_force = 1'b0; uart_mode = 1'b1;
    bus.we = 1'b1; bus.w_data = 8'h77;
    cyc(1);
    bus.we = 1'b0;
    chk("fullpop_overflow", 32'(bus.overflow), 32'd1);
    chk("fullpop_level", 32'(bus.level), 32'd255);
    chk("fullpop_start", 32'(bus.start), 32'd1);
    chk("fullpop_tx_data", 32'(bus.tx_data), 32'h00);
    bus.clr_err = 1'b1;
    cyc(1);
    bus.clr_err = 1'b0;
    wait_drained("drain256_done");
    chk("drain256_count", 32'(rxq.size()), 32'd256);
    mism = 0;
    for (int k = 0; k < rxq.size(); k++) if (rxq[k] !== k[7:0]) mism++;
    chk("drain256_order", 32'(mism), 32'd0);

    // Simultaneous write and pop at level 5.
    uart_mode = 1'b0; busy_force = 1'b1;
    cyc(2);
    for (int i = 0; i < 5; i++) begin
      bus.we = 1'b1; bus.w_data = 8'h10 + i[7:0];
      cyc(1);
    end
    bus.we = 1'b0;
    chk("lvl5_before", 32'(bus.level), 32'd5);
    rxq.delete();
    bus.we = 1'b1; bus.w_data = 8'h15; busy_force = 1'b0;
    cyc(1);
    bus.we = 1'b0; uart_mode = 1'b1;
    chk("lvl5_after", 32'(bus.level), 32'd5);
    chk("lvl5_start", 32'(bus.start), 32'd1);
    chk("lvl5_tx_data", 32'(bus.tx_data), 32'h10);
    wait_drained("lvl5_done");
    chk("lvl5_count", 32'(rxq.size()), 32'd6);

    // 300 random bytes in bursts, crossing pointer wrap.
    rxq.delete(); expq.delete();
    total = 0;
    while (total < 300) begin
      burst = $urandom_range(1, 20);
      if (burst > 300 - total) burst = 300 - total;
      for (int j = 0; j < burst; j++) begin
        d = 8'($urandom);
        bus.we = 1'b1; bus.w_data = d;
        expq.push_back(d);
        cyc(1);
      end
      bus.we = 1'b0;
      total += burst;
      cyc($urandom_range(40, 250));
    end
    wait_drained("wrap_done");
    chk("wrap_count", 32'(rxq.size()), 32'd300);
    mism = 0;
    for (int k = 0; k < rxq.size() && k < expq.size(); k++) if (rxq[k] !== expq[k]) mism++;
    chk("wrap_order", 32'(mism), 32'd0);
    chk("wrap_no_overflow", 32'(bus.overflow), 32'd0);

    // Reset while the UART is busy with a byte.
    bus.we = 1'b1; bus.w_data = 8'h5A; cyc(1);
    bus.w_data = 8'h5B; cyc(1);
    bus.w_data = 8'h5C; cyc(1);
    bus.we = 1'b0;
    cyc(5);
    chk("midrst_busy_before", 32'(bus.tx_busy), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_start", 32'(bus.start), 32'd0);
    chk("midrst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_level", 32'(bus.level), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(15);

`ifdef FIFO_TX_DRAIN_FLUSH_EN
    // Flush at level 10, with a competing write.
    uart_mode = 1'b0; busy_force = 1'b1;
    cyc(2);
    for (int i = 0; i < 10; i++) begin
      bus.we = 1'b1; bus.w_data = 8'h30 + i[7:0];
      cyc(1);
    end
    bus.we = 1'b0;
    chk("flush_level_before", 32'(bus.level), 32'd10);
    flush = 1'b1; bus.we = 1'b1; bus.w_data = 8'h99;
    cyc(1);
    flush = 1'b0; bus.we = 1'b0;
    chk("flush_level_after", 32'(bus.level), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    busy_force = 1'b0;
    cyc(20);
`endif

    cyc(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
